// File: rtl/sram_multiport_arbiter.sv
// ---------------------------------------------------------------------------
// sram_multiport_arbiter
//
// N-channel Avalon-MM front end for an external asynchronous SRAM (frame
// buffer). Client channels (scan-out, pixel writer, CPU, ...) compete for the
// single SRAM. One access runs at a time, with programmable read and write
// wait states. Read data returns to the issuing channel with a one-cycle
// readdatavalid pulse.
//
// Parameters
//   NUM_CH   number of client channels (1..8)
//   AW       SRAM word-address width
//   DW       data width (multiple of 8), BW = DW/8 byte lanes
//   RD_WAIT  extra SRAM cycles per read (0..15)
//   WR_WAIT  extra WE_N-low cycles per write (0..15)
//   ARB_MODE 0 = fixed priority (ch0 highest), 1 = round-robin
//
// Ports
//   clk, reset (async, active low)
//   ch_address/byteenable/read/write/writedata : per-channel commands,
//       channel i occupies slice [i*W +: W] of each packed vector
//   ch_waitrequest   : 1 = command not accepted this cycle
//   ch_readdata      : read data (qualified by ch_readdatavalid)
//   ch_readdatavalid : one-cycle read-return pulse per channel
//   SRAM_DQ          : bidirectional SRAM data bus
//   SRAM_ADDR, SRAM_BE_N, SRAM_CE_N, SRAM_OE_N, SRAM_WE_N : registered strobes
// ---------------------------------------------------------------------------
module sram_multiport_arbiter #(
  parameter int NUM_CH   = 2,
  parameter int AW       = 20,
  parameter int DW       = 16,
  parameter int RD_WAIT  = 1,
  parameter int WR_WAIT  = 1,
  parameter int ARB_MODE = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_CH*AW-1:0]     ch_address,
  input  logic [NUM_CH*(DW/8)-1:0] ch_byteenable,
  input  logic [NUM_CH-1:0]        ch_read,
  input  logic [NUM_CH-1:0]        ch_write,
  input  logic [NUM_CH*DW-1:0]     ch_writedata,
  output logic [NUM_CH-1:0]        ch_waitrequest,
  output logic [NUM_CH*DW-1:0]     ch_readdata,
  output logic [NUM_CH-1:0]        ch_readdatavalid,
  inout  wire  [DW-1:0]            SRAM_DQ,
  output logic [AW-1:0]            SRAM_ADDR,
  output logic [DW/8-1:0]          SRAM_BE_N,
  output logic                     SRAM_CE_N,
  output logic                     SRAM_OE_N,
  output logic                     SRAM_WE_N
);

  localparam int BW = DW / 8;
  localparam int IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD      = 2'd1,
    ST_WR      = 2'd2,
    ST_WR_HOLD = 2'd3
  } state_t;

  state_t              state_r;
  logic [3:0]          wait_cnt_r;
  logic [IW-1:0]       grant_r;
  logic [IW-1:0]       rr_ptr_r;
  logic [DW-1:0]       rdata_r;
  logic [NUM_CH-1:0]   rdv_r;
  logic [DW-1:0]       dq_out_r;
  logic                dq_oe_r;

  logic [NUM_CH-1:0]   req_s;
  logic                grant_vld_s;
  logic [IW-1:0]       grant_idx_s;
  logic [IW-1:0]       cand_s;
  logic [AW-1:0]       sel_addr_s;
  logic [BW-1:0]       sel_be_s;
  logic [DW-1:0]       sel_wdata_s;
  logic                sel_wr_s;

  // A write request dominates a simultaneous read; both count as a request.
  assign req_s = ch_read | ch_write;

  // The data bus is only driven while a write (or its hold cycle) is active.
  assign SRAM_DQ = dq_oe_r ? dq_out_r : {DW{1'bz}};

  // One shared return register; each channel's readdata is qualified by its own valid.
  assign ch_readdata      = {NUM_CH{rdata_r}};
  assign ch_readdatavalid = rdv_r;

  // Arbitration: pick the winning channel among current requesters.
  always_comb begin
    grant_vld_s = 1'b0;
    grant_idx_s = '0;
    cand_s      = '0;
    if (ARB_MODE == 0) begin
      // Scan downward so the lowest requesting index is the final winner.
      for (int i = NUM_CH - 1; i >= 0; i--) begin
        if (req_s[IW'(i)]) begin
          grant_vld_s = 1'b1;
          grant_idx_s = IW'(i);
        end else begin
          grant_idx_s = grant_idx_s;
        end
      end
    end else begin
      // Scan distances NUM_CH..1 after the last grant; the nearest requester wins.
      for (int k = NUM_CH; k >= 1; k--) begin
        cand_s = IW'((int'(rr_ptr_r) + k) % NUM_CH);
        if (req_s[cand_s]) begin
          grant_vld_s = 1'b1;
          grant_idx_s = cand_s;
        end else begin
          grant_idx_s = grant_idx_s;
        end
      end
    end
  end

  // Command mux: the winner's address, byte enables, data and operation.
  always_comb begin
    sel_addr_s  = ch_address[grant_idx_s*AW +: AW];
    sel_be_s    = ch_byteenable[grant_idx_s*BW +: BW];
    sel_wdata_s = ch_writedata[grant_idx_s*DW +: DW];
    sel_wr_s    = ch_write[grant_idx_s];
  end

  // Waitrequest: only the IDLE-state winner is released; held high during reset.
  always_comb begin
    ch_waitrequest = '1;
    if (reset && (state_r == ST_IDLE) && grant_vld_s) begin
      ch_waitrequest[grant_idx_s] = 1'b0;
    end else begin
      ch_waitrequest = '1;
    end
  end

  // Access FSM with registered SRAM strobes, read return and RR pointer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r    <= ST_IDLE;
      wait_cnt_r <= 4'd0;
      grant_r    <= '0;
      rr_ptr_r   <= IW'(NUM_CH - 1);
      rdata_r    <= '0;
      rdv_r      <= '0;
      dq_out_r   <= '0;
      dq_oe_r    <= 1'b0;
      SRAM_ADDR  <= '0;
      SRAM_BE_N  <= '1;
      SRAM_CE_N  <= 1'b1;
      SRAM_OE_N  <= 1'b1;
      SRAM_WE_N  <= 1'b1;
    end else begin
      rdv_r <= '0;
      case (state_r)
        ST_IDLE: begin
          if (grant_vld_s) begin
            grant_r    <= grant_idx_s;
            wait_cnt_r <= 4'd0;
            SRAM_ADDR  <= sel_addr_s;
            SRAM_BE_N  <= ~sel_be_s;
            SRAM_CE_N  <= 1'b0;
            if (ARB_MODE != 0) begin
              rr_ptr_r <= grant_idx_s;
            end else begin
              rr_ptr_r <= rr_ptr_r;
            end
            if (sel_wr_s) begin
              state_r   <= ST_WR;
              SRAM_WE_N <= 1'b0;
              SRAM_OE_N <= 1'b1;
              dq_out_r  <= sel_wdata_s;
              dq_oe_r   <= 1'b1;
            end else begin
              state_r   <= ST_RD;
              SRAM_OE_N <= 1'b0;
              SRAM_WE_N <= 1'b1;
              dq_oe_r   <= 1'b0;
            end
          end else begin
            state_r   <= ST_IDLE;
            SRAM_BE_N <= '1;
            SRAM_CE_N <= 1'b1;
            SRAM_OE_N <= 1'b1;
            SRAM_WE_N <= 1'b1;
            dq_oe_r   <= 1'b0;
          end
        end
        ST_RD: begin
          if (wait_cnt_r == 4'(RD_WAIT)) begin
            // Sample the bus at the end of the final read cycle.
            rdata_r          <= SRAM_DQ;
            rdv_r[grant_r]   <= 1'b1;
            state_r          <= ST_IDLE;
            SRAM_CE_N        <= 1'b1;
            SRAM_OE_N        <= 1'b1;
            SRAM_BE_N        <= '1;
          end else begin
            wait_cnt_r <= wait_cnt_r + 4'd1;
          end
        end
        ST_WR: begin
          if (wait_cnt_r == 4'(WR_WAIT)) begin
            // Raise WE_N one cycle before releasing data/CE_N for hold time.
            state_r   <= ST_WR_HOLD;
            SRAM_WE_N <= 1'b1;
          end else begin
            wait_cnt_r <= wait_cnt_r + 4'd1;
          end
        end
        ST_WR_HOLD: begin
          state_r   <= ST_IDLE;
          SRAM_CE_N <= 1'b1;
          SRAM_BE_N <= '1;
          dq_oe_r   <= 1'b0;
        end
        default: begin
          state_r   <= ST_IDLE;
          SRAM_CE_N <= 1'b1;
          SRAM_OE_N <= 1'b1;
          SRAM_WE_N <= 1'b1;
          SRAM_BE_N <= '1;
          dq_oe_r   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_multiport_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sram_multiport_arbiter
//
// Two instances: A (2 channels, fixed priority, RD_WAIT=1, WR_WAIT=1) and
// B (3 channels, round-robin, RD_WAIT=3, WR_WAIT=1), each with a small
// behavioural SRAM. Read data is checked through per-channel expected-data
// queues filled when a read is issued and drained on readdatavalid.
// ---------------------------------------------------------------------------
module tb_sram_multiport_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_a, reset_b;

  // Instance A signals
  logic [39:0] a_addr;
  logic [3:0]  a_be;
  logic [1:0]  a_rd, a_wr, a_wait, a_rdv;
  logic [31:0] a_wd, a_rdata;
  wire  [15:0] dq_a;
  logic [19:0] a_saddr;
  logic [1:0]  a_be_n;
  logic        a_ce_n, a_oe_n, a_we_n;

  // Instance B signals
  logic [59:0] b_addr;
  logic [5:0]  b_be;
  logic [2:0]  b_rd, b_wr, b_wait, b_rdv;
  logic [47:0] b_wd, b_rdata;
  wire  [15:0] dq_b;
  logic [19:0] b_saddr;
  logic [1:0]  b_be_n;
  logic        b_ce_n, b_oe_n, b_we_n;

  logic [15:0] mem_a [0:255];
  logic [15:0] mem_b [0:255];

  logic [15:0] exp_q0 [$];
  logic [15:0] exp_q1 [$];
  int          n_checks = 0;
  int          n_pass   = 0;
  logic        overlap_seen = 1'b0;

  sram_multiport_arbiter #(
    .NUM_CH(2), .AW(20), .DW(16), .RD_WAIT(1), .WR_WAIT(1), .ARB_MODE(0)
  ) dut_a (
    .clk(clk), .reset(reset_a),
    .ch_address(a_addr), .ch_byteenable(a_be), .ch_read(a_rd), .ch_write(a_wr),
    .ch_writedata(a_wd), .ch_waitrequest(a_wait), .ch_readdata(a_rdata),
    .ch_readdatavalid(a_rdv), .SRAM_DQ(dq_a), .SRAM_ADDR(a_saddr),
    .SRAM_BE_N(a_be_n), .SRAM_CE_N(a_ce_n), .SRAM_OE_N(a_oe_n), .SRAM_WE_N(a_we_n)
  );

  sram_multiport_arbiter #(
    .NUM_CH(3), .AW(20), .DW(16), .RD_WAIT(3), .WR_WAIT(1), .ARB_MODE(1)
  ) dut_b (
    .clk(clk), .reset(reset_b),
    .ch_address(b_addr), .ch_byteenable(b_be), .ch_read(b_rd), .ch_write(b_wr),
    .ch_writedata(b_wd), .ch_waitrequest(b_wait), .ch_readdata(b_rdata),
    .ch_readdatavalid(b_rdv), .SRAM_DQ(dq_b), .SRAM_ADDR(b_saddr),
    .SRAM_BE_N(b_be_n), .SRAM_CE_N(b_ce_n), .SRAM_OE_N(b_oe_n), .SRAM_WE_N(b_we_n)
  );

  // Behavioural SRAMs: drive the bus while CE_N and OE_N are low.
  assign dq_a = (!a_ce_n && !a_oe_n) ? mem_a[a_saddr[7:0]] : 16'hzzzz;
  assign dq_b = (!b_ce_n && !b_oe_n) ? mem_b[b_saddr[7:0]] : 16'hzzzz;

  // SRAM A write: each enabled byte lane follows the bus while WE_N is low.
  always @(posedge clk) begin
    if (!a_ce_n && !a_we_n) begin
      if (!a_be_n[0]) mem_a[a_saddr[7:0]][7:0]  <= dq_a[7:0];
      if (!a_be_n[1]) mem_a[a_saddr[7:0]][15:8] <= dq_a[15:8];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // Read-return scoreboard and strobe-overlap watch.
  always @(negedge clk) begin
    if (reset_a) begin
      if (a_rdv[0]) begin
        if (exp_q0.size() == 0) chk("rdv0_unexpected", 32'd1, 32'd0);
        else chk("rd0_data", {16'd0, a_rdata[15:0]}, {16'd0, exp_q0.pop_front()});
      end
      if (a_rdv[1]) begin
        if (exp_q1.size() == 0) chk("rdv1_unexpected", 32'd1, 32'd0);
        else chk("rd1_data", {16'd0, a_rdata[31:16]}, {16'd0, exp_q1.pop_front()});
      end
    end
    if ((!a_oe_n && !a_we_n) || (!b_oe_n && !b_we_n)) overlap_seen = 1'b1;
  end

  // Present a command on A and hold it until accepted; returns just after the accept edge.
  task automatic a_issue(input int ch, input bit wr, input bit rd, input logic [19:0] addr,
                         input logic [1:0] be, input logic [15:0] wd);
    int n;
    a_addr[ch*20 +: 20] = addr;
    a_be[ch*2 +: 2]     = be;
    a_wd[ch*16 +: 16]   = wd;
    a_rd[ch]            = rd;
    a_wr[ch]            = wr;
    n = 0;
    #1;
    while (a_wait[ch] && n < 50) begin
      @(negedge clk); #1; n++;
    end
    if (n >= 50) chk("accept_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    a_rd[ch] = 1'b0;
    a_wr[ch] = 1'b0;
  endtask

  task automatic a_write(input int ch, input bit also_rd, input logic [19:0] addr,
                         input logic [1:0] be, input logic [15:0] wd,
                         output int we_cycles, output logic [1:0] be_n_seen);
    a_issue(ch, 1'b1, also_rd, addr, be, wd);
    we_cycles = 0;
    be_n_seen = 2'b11;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (!a_we_n) begin
        we_cycles++;
        be_n_seen = a_be_n;
      end
    end
  endtask

  task automatic a_read(input int ch, input logic [19:0] addr, input logic [1:0] be,
                        input logic [15:0] exp_data, output int lat, output logic [1:0] be_n_seen);
    if (ch == 0) exp_q0.push_back(exp_data);
    else exp_q1.push_back(exp_data);
    a_issue(ch, 1'b0, 1'b1, addr, be, 16'h0000);
    lat = 0;
    be_n_seen = 2'b11;
    do begin
      @(negedge clk);
      lat++;
      if (!a_oe_n) be_n_seen = a_be_n;
    end while (!a_rdv[ch] && lat < 20);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int          we_n_cnt, lat, g0, n, rdv_cnt;
    logic [1:0]  ben;
    logic        ch1_granted;
    int          grants [$];

    reset_a = 1'b0; reset_b = 1'b0;
    a_addr = '0; a_be = '0; a_rd = '0; a_wr = '0; a_wd = '0;
    b_addr = '0; b_be = '1; b_rd = '0; b_wr = '0; b_wd = '0;

    // Reset state, with a pending request that must not be released.
    a_rd[0] = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_waitrequest", {30'd0, a_wait}, 32'h3);
    chk("rst_strobes", {29'd0, a_ce_n, a_oe_n, a_we_n}, 32'h7);
    chk("rst_be_n", {30'd0, a_be_n}, 32'h3);
    chk("rst_addr", {12'd0, a_saddr}, 32'h0);
    chk("rst_rdv", {30'd0, a_rdv}, 32'h0);
    chk("rst_rdata", a_rdata, 32'h0);
    a_rd[0] = 1'b0;
    @(negedge clk);
    reset_a = 1'b1; reset_b = 1'b1;
    @(negedge clk);

    // Single write then read.
    a_write(0, 1'b0, 20'h00010, 2'b11, 16'hBEEF, we_n_cnt, ben);
    chk("wr_we_low_cycles", we_n_cnt, 32'd2);
    a_read(0, 20'h00010, 2'b11, 16'hBEEF, lat, ben);
    chk("rd_latency", lat, 32'd3);

    // Byte lanes.
    a_write(0, 1'b0, 20'h00020, 2'b11, 16'hBEEF, we_n_cnt, ben);
    a_write(0, 1'b0, 20'h00020, 2'b01, 16'h0012, we_n_cnt, ben);
    chk("lane_be_n", {30'd0, ben}, 32'h2);
    chk("lane_we_low_cycles", we_n_cnt, 32'd2);
    a_read(0, 20'h00020, 2'b11, 16'hBE12, lat, ben);

    // Byteenable = 0: access runs as a no-op, read still returns a pulse.
    a_write(0, 1'b0, 20'h00010, 2'b00, 16'h0000, we_n_cnt, ben);
    chk("be0_wr_be_n", {30'd0, ben}, 32'h3);
    a_read(0, 20'h00010, 2'b00, 16'hBEEF, lat, ben);
    chk("be0_rd_latency", lat, 32'd3);
    chk("be0_rd_be_n", {30'd0, ben}, 32'h3);

    // Fixed priority: ch0 reads back-to-back while ch1 holds a write.
    a_addr[39:20] = 20'h00030; a_wd[31:16] = 16'h5555; a_be[3:2] = 2'b11; a_wr[1] = 1'b1;
    a_addr[19:0]  = 20'h00010; a_be[1:0] = 2'b11; a_rd[0] = 1'b1;
    g0 = 0; ch1_granted = 1'b0;
    for (int i = 0; i < 12; i++) begin
      #1;
      if (!a_wait[0]) begin
        g0++;
        exp_q0.push_back(16'hBEEF);
      end
      if (!a_wait[1]) ch1_granted = 1'b1;
      @(negedge clk);
    end
    a_rd[0] = 1'b0;
    chk("fixed_ch0_grants", g0, 32'd4);
    chk("fixed_ch1_blocked", {31'd0, ch1_granted}, 32'd0);
    a_issue(1, 1'b1, 1'b0, 20'h00030, 2'b11, 16'h5555);
    repeat (4) @(negedge clk);
    a_read(1, 20'h00030, 2'b11, 16'h5555, lat, ben);
    chk("ch1_rd_latency", lat, 32'd3);

    // Read+write together on ch1: only the write happens.
    a_write(1, 1'b1, 20'h00040, 2'b11, 16'hA5A5, we_n_cnt, ben);
    chk("conflict_we_low_cycles", we_n_cnt, 32'd2);
    a_read(1, 20'h00040, 2'b11, 16'hA5A5, lat, ben);

    // Round-robin on B: all channels request continuously.
    b_rd = 3'b111;
    n = 0;
    while (grants.size() < 6 && n < 60) begin
      #1;
      for (int c = 0; c < 3; c++) if (!b_wait[c]) grants.push_back(c);
      @(negedge clk);
      n++;
    end
    b_rd = 3'b000;
    chk("rr_grant_count", grants.size(), 32'd6);
    for (int k = 0; k < 6 && k < grants.size(); k++) chk("rr_grant_order", grants[k], k % 3);

    // Reset in the middle of a B read.
    repeat (10) @(negedge clk);
    b_addr[19:0] = 20'h00005;
    b_rd[0] = 1'b1;
    n = 0;
    #1;
    while (b_wait[0] && n < 50) begin
      @(negedge clk); #1; n++;
    end
    if (n >= 50) chk("b_accept_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    b_rd[0] = 1'b0;
    @(negedge clk);
    chk("b_in_read_oe_n", {31'd0, b_oe_n}, 32'd0);
    b_rd = 3'b111;
    reset_b = 1'b0;
    #1;
    chk("midrst_strobes", {29'd0, b_ce_n, b_oe_n, b_we_n}, 32'h7);
    chk("midrst_be_n", {30'd0, b_be_n}, 32'h3);
    chk("midrst_waitrequest", {29'd0, b_wait}, 32'h7);
    @(negedge clk);
    b_rd = 3'b000;
    reset_b = 1'b1;
    rdv_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (b_rdv != 3'b000) rdv_cnt++;
    end
    chk("midrst_no_rdv", rdv_cnt, 32'd0);

    // Drain and final consistency.
    repeat (10) @(negedge clk);
    chk("sb_q0_empty", exp_q0.size(), 32'd0);
    chk("sb_q1_empty", exp_q1.size(), 32'd0);
    chk("oe_we_overlap", {31'd0, overlap_seen}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
